cv32e40p_tmr_voter: RTL and testbench

- Downstream consumer of the triplicated multiplier/ALU wrapper.
- Majority-votes the three replica outputs (result, comparison_result, ready) into one corrected stream for the EX stage.
- Counts and localises replica mismatches; after a persistent fault, excludes the faulty replica (degraded duplex mode).
- Flags uncorrectable disagreement. Voted data path is combinational; fault bookkeeping is sequential.

---
 rtl/cv32e40p_pkg.sv | 15 +
 rtl/cv32e40p_tmr_voter_if.sv | 27 ++
 rtl/cv32e40p_tmr_maj3.sv | 13 +
 rtl/cv32e40p_tmr_voter.sv | 185 ++++++++++++++++++
 tb/tb_cv32e40p_tmr_voter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR voter: FSM state encoding and the voted tuple width.
// A tuple is {ready, comparison_result, result}.
package cv32e40p_pkg;

    localparam int TMR_TUPLE_W = 34;

    typedef logic [TMR_TUPLE_W-1:0] tmr_tuple_t;

    typedef enum logic [1:0] {
        TMR_HEALTHY  = 2'd0,
        TMR_DEGRADED = 2'd1,
        TMR_FAIL     = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/cv32e40p_tmr_voter_if.sv
// Replica-side bus: the three outputs of the triplicated multiplier/ALU wrapper.
// The wrapper drives it (master); the voter consumes it (slave).
interface cv32e40p_tmr_voter_if;

    logic [31:0] result_1_i;
    logic [31:0] result_2_i;
    logic [31:0] result_3_i;
    logic        comparison_result_1_i;
    logic        comparison_result_2_i;
    logic        comparison_result_3_i;
    logic        ready_1_i;
    logic        ready_2_i;
    logic        ready_3_i;

    modport master (
        output result_1_i, result_2_i, result_3_i,
        output comparison_result_1_i, comparison_result_2_i, comparison_result_3_i,
        output ready_1_i, ready_2_i, ready_3_i
    );

    modport slave (
        input result_1_i, result_2_i, result_3_i,
        input comparison_result_1_i, comparison_result_2_i, comparison_result_3_i,
        input ready_1_i, ready_2_i, ready_3_i
    );

endinterface

// File: rtl/cv32e40p_tmr_maj3.sv
// Bitwise 2-of-3 majority of three equal-width words.
module cv32e40p_tmr_maj3 #(
    parameter int W = 34
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/cv32e40p_tmr_voter.sv
// Majority voter for the triplicated multiplier/ALU: combinational voted stream,
// sequential mismatch bookkeeping with fault exclusion (duplex) and sticky failure.
module cv32e40p_tmr_voter
    import cv32e40p_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic                   ex_ready_i,
    input  logic                   clear_i,
    cv32e40p_tmr_voter_if.slave    rep,
    output logic [31:0]            result_o,
    output logic                   comparison_result_o,
    output logic                   ready_o,
    output logic                   err_detect_o,
    output logic                   uncorrectable_o,
    output logic [2:0]             faulty_mask_o,
    output logic [1:0]             state_o,
    output logic [3*CNT_W-1:0]     err_cnt_o
);

    localparam logic [2:0]       THR     = 3'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tmr_state_e       state_q, state_d;
    logic [2:0]       faulty_mask_q, faulty_mask_d;
    logic             uncorrectable_q, uncorrectable_d;
    logic [2:0]       cons_q [3];
    logic [2:0]       cons_d [3];
    logic [CNT_W-1:0] err_cnt_q [3];
    logic [CNT_W-1:0] err_cnt_d [3];

    tmr_tuple_t tup [3];
    tmr_tuple_t maj_tup;
    tmr_tuple_t tup_a;
    tmr_tuple_t tup_b;
    tmr_tuple_t voted;
    logic [2:0] mismatch;
    logic [2:0] reach;
    logic       qualified;

    // Held for stall-aware extensions; deliberately has no effect on outputs.
    logic unused_ex_ready;
    assign unused_ex_ready = ex_ready_i;

    assign tup[0] = {rep.ready_1_i, rep.comparison_result_1_i, rep.result_1_i};
    assign tup[1] = {rep.ready_2_i, rep.comparison_result_2_i, rep.result_2_i};
    assign tup[2] = {rep.ready_3_i, rep.comparison_result_3_i, rep.result_3_i};

    cv32e40p_tmr_maj3 #(
        .W (TMR_TUPLE_W)
    ) u_maj3 (
        .a_i   (tup[0]),
        .b_i   (tup[1]),
        .c_i   (tup[2]),
        .maj_o (maj_tup)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= TMR_HEALTHY;
            faulty_mask_q   <= 3'b000;
            uncorrectable_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cons_q[k]    <= 3'd0;
                err_cnt_q[k] <= '0;
            end
        end else begin
            state_q         <= state_d;
            faulty_mask_q   <= faulty_mask_d;
            uncorrectable_q <= uncorrectable_d;
            for (int k = 0; k < 3; k++) begin
                cons_q[k]    <= cons_d[k];
                err_cnt_q[k] <= err_cnt_d[k];
            end
        end
    end

    // Output logic: voting and per-replica mismatch, all combinational.
    always_comb begin
        tup_a    = tup[0];
        tup_b    = tup[1];
        voted    = maj_tup;
        mismatch = 3'b000;
        // Active pair once a replica is excluded; lowest index drives the output.
        if (faulty_mask_q[0]) begin
            tup_a = tup[1];
            tup_b = tup[2];
        end else if (faulty_mask_q[1]) begin
            tup_a = tup[0];
            tup_b = tup[2];
        end
        if (state_q == TMR_HEALTHY) begin
            voted = maj_tup;
            for (int k = 0; k < 3; k++) begin
                mismatch[k] = (tup[k] != maj_tup);
            end
        end else begin
            voted    = tup_a;
            mismatch = {3{tup_a != tup_b}} & ~faulty_mask_q;
        end
        qualified    = enable_i & voted[TMR_TUPLE_W-1];
        err_detect_o = qualified & (|mismatch);
    end

    assign result_o            = voted[31:0];
    assign comparison_result_o = voted[32];
    assign ready_o             = voted[33];

    // Next-state logic: counters, thresholds and fault exclusion.
    always_comb begin
        state_d         = state_q;
        faulty_mask_d   = faulty_mask_q;
        uncorrectable_d = uncorrectable_q;
        reach           = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cons_d[k]    = cons_q[k];
            err_cnt_d[k] = err_cnt_q[k];
        end

        if (clear_i) begin
            state_d         = TMR_HEALTHY;
            faulty_mask_d   = 3'b000;
            uncorrectable_d = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cons_d[k]    = 3'd0;
                err_cnt_d[k] = '0;
            end
        end else begin
            case (state_q)
                TMR_HEALTHY: begin
                    if (qualified) begin
                        for (int k = 0; k < 3; k++) begin
                            if (mismatch[k]) begin
                                if (err_cnt_q[k] != CNT_MAX) err_cnt_d[k] = err_cnt_q[k] + CNT_ONE;
                                if (cons_q[k] != THR)        cons_d[k]    = cons_q[k] + 3'd1;
                            end else begin
                                cons_d[k] = 3'd0;
                            end
                            reach[k] = mismatch[k] && (cons_d[k] == THR);
                        end
                        // Two replicas condemned at once leaves no trustworthy pair.
                        if ((reach & (reach - 3'd1)) != 3'd0) begin
                            state_d         = TMR_FAIL;
                            uncorrectable_d = 1'b1;
                            faulty_mask_d   = reach[0] ? 3'b001 : 3'b010;
                        end else if (|reach) begin
                            state_d       = TMR_DEGRADED;
                            faulty_mask_d = reach;
                        end
                    end
                end
                TMR_DEGRADED: begin
                    if (qualified && (|mismatch)) begin
                        for (int k = 0; k < 3; k++) begin
                            if (mismatch[k] && (err_cnt_q[k] != CNT_MAX)) begin
                                err_cnt_d[k] = err_cnt_q[k] + CNT_ONE;
                            end
                        end
                        state_d         = TMR_FAIL;
                        uncorrectable_d = 1'b1;
                    end
                end
                default: begin
                    state_d         = TMR_FAIL;
                    uncorrectable_d = 1'b1;
                end
            endcase
        end
    end

    assign uncorrectable_o = uncorrectable_q;
    assign faulty_mask_o   = faulty_mask_q;
    assign state_o         = state_q;

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        assign err_cnt_o[g*CNT_W +: CNT_W] = err_cnt_q[g];
    end

endmodule

// File: tb/tb_cv32e40p_tmr_voter.sv
// Directed bench for the TMR voter: main instance (CNT_W=8, THRESH=3) plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_cv32e40p_tmr_voter;

    localparam logic [31:0] NOM = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        ex_ready_i;
    logic        clear_i;
    logic [31:0] result_o;
    logic        comparison_result_o;
    logic        ready_o;
    logic        err_detect_o;
    logic        uncorrectable_o;
    logic [2:0]  faulty_mask_o;
    logic [1:0]  state_o;
    logic [23:0] err_cnt_o;

    logic [31:0] s_result_o;
    logic        s_comparison_result_o;
    logic        s_ready_o;
    logic        s_err_detect_o;
    logic        s_uncorrectable_o;
    logic [2:0]  s_faulty_mask_o;
    logic [1:0]  s_state_o;
    logic [5:0]  s_err_cnt_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_tmr_voter_if rep ();

    always #5 clk = ~clk;

    cv32e40p_tmr_voter #(.CNT_W(8), .THRESH(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .ex_ready_i          (ex_ready_i),
        .clear_i             (clear_i),
        .rep                 (rep),
        .result_o            (result_o),
        .comparison_result_o (comparison_result_o),
        .ready_o             (ready_o),
        .err_detect_o        (err_detect_o),
        .uncorrectable_o     (uncorrectable_o),
        .faulty_mask_o       (faulty_mask_o),
        .state_o             (state_o),
        .err_cnt_o           (err_cnt_o)
    );

    cv32e40p_tmr_voter #(.CNT_W(2), .THRESH(3)) dut_sat (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .ex_ready_i          (ex_ready_i),
        .clear_i             (clear_i),
        .rep                 (rep),
        .result_o            (s_result_o),
        .comparison_result_o (s_comparison_result_o),
        .ready_o             (s_ready_o),
        .err_detect_o        (s_err_detect_o),
        .uncorrectable_o     (s_uncorrectable_o),
        .faulty_mask_o       (s_faulty_mask_o),
        .state_o             (s_state_o),
        .err_cnt_o           (s_err_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nominal();
        rep.result_1_i = NOM;
        rep.result_2_i = NOM;
        rep.result_3_i = NOM;
        rep.comparison_result_1_i = 1'b1;
        rep.comparison_result_2_i = 1'b1;
        rep.comparison_result_3_i = 1'b1;
        rep.ready_1_i = 1'b1;
        rep.ready_2_i = 1'b1;
        rep.ready_3_i = 1'b1;
        enable_i   = 1'b1;
        ex_ready_i = 1'b1;
        clear_i    = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        nominal();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (faulty_mask_o !== 3'b000) begin errors++; $display("FAIL reset_mask got %b exp 000", faulty_mask_o); end
        checks++; if (uncorrectable_o !== 1'b0) begin errors++; $display("FAIL reset_unc got %b exp 0", uncorrectable_o); end
        checks++; if (err_cnt_o !== 24'h0) begin errors++; $display("FAIL reset_cnt got %h exp 000000", err_cnt_o); end
        checks++; if (s_err_cnt_o !== 6'h0) begin errors++; $display("FAIL reset_sat_cnt got %h exp 00", s_err_cnt_o); end
    endtask

    task automatic test_fault_free();
        for (int i = 0; i < 10; i++) begin
            nominal();
            #1;
            checks++; if (result_o !== NOM) begin errors++; $display("FAIL ff_result cyc %0d got %h exp %h", i, result_o, NOM); end
            checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL ff_detect cyc %0d got %b exp 0", i, err_detect_o); end
            tick();
        end
        checks++; if (err_cnt_o !== 24'h0) begin errors++; $display("FAIL ff_cnt got %h exp 000000", err_cnt_o); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL ff_state got %0d exp 0", state_o); end
    endtask

    task automatic test_transient();
        nominal();
        rep.result_2_i = 32'h1234_5679;
        #1;
        checks++; if (result_o !== NOM) begin errors++; $display("FAIL tr_result got %h exp %h", result_o, NOM); end
        checks++; if (err_detect_o !== 1'b1) begin errors++; $display("FAIL tr_detect got %b exp 1", err_detect_o); end
        tick();
        checks++; if (err_cnt_o !== {8'd0, 8'd1, 8'd0}) begin errors++; $display("FAIL tr_cnt got %h exp 000100", err_cnt_o); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL tr_state got %0d exp 0", state_o); end
        nominal();
        #1;
        checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL tr_detect_after got %b exp 0", err_detect_o); end
        tick();
        // Two more mismatches only stay below threshold if the match above cleared cons_2.
        for (int i = 0; i < 2; i++) begin
            rep.result_2_i = 32'h0000_0001;
            tick();
        end
        nominal();
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL tr_cons_clear got %0d exp 0", state_o); end
        checks++; if (err_cnt_o !== {8'd0, 8'd3, 8'd0}) begin errors++; $display("FAIL tr_cnt2 got %h exp 000300", err_cnt_o); end
    endtask

    task automatic test_persistent();
        for (int i = 0; i < 3; i++) begin
            nominal();
            rep.comparison_result_3_i = 1'b0;
            #1;
            checks++; if (comparison_result_o !== 1'b1) begin errors++; $display("FAIL pf_cmp cyc %0d got %b exp 1", i, comparison_result_o); end
            checks++; if (err_detect_o !== 1'b1) begin errors++; $display("FAIL pf_detect cyc %0d got %b exp 1", i, err_detect_o); end
            tick();
            if (i < 2) begin
                checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL pf_state_early cyc %0d got %0d exp 0", i, state_o); end
            end
        end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL pf_state got %0d exp 1", state_o); end
        checks++; if (faulty_mask_o !== 3'b100) begin errors++; $display("FAIL pf_mask got %b exp 100", faulty_mask_o); end
        checks++; if (err_cnt_o !== {8'd3, 8'd3, 8'd0}) begin errors++; $display("FAIL pf_cnt got %h exp 030300", err_cnt_o); end
        rep.result_3_i = 32'hFFFF_0000;
        #1;
        checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL pf_ignored_detect got %b exp 0", err_detect_o); end
        checks++; if (result_o !== NOM) begin errors++; $display("FAIL pf_ignored_result got %h exp %h", result_o, NOM); end
        tick();
        checks++; if (err_cnt_o !== {8'd3, 8'd3, 8'd0}) begin errors++; $display("FAIL pf_hold_cnt got %h exp 030300", err_cnt_o); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL pf_hold_state got %0d exp 1", state_o); end
    endtask

    task automatic test_divergence();
        nominal();
        rep.result_1_i = 32'hDEAD_BEEF;
        rep.result_2_i = 32'h0000_0000;
        #1;
        checks++; if (result_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dv_result got %h exp deadbeef", result_o); end
        checks++; if (err_detect_o !== 1'b1) begin errors++; $display("FAIL dv_detect got %b exp 1", err_detect_o); end
        tick();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dv_state got %0d exp 2", state_o); end
        checks++; if (uncorrectable_o !== 1'b1) begin errors++; $display("FAIL dv_unc got %b exp 1", uncorrectable_o); end
        checks++; if (err_cnt_o !== {8'd3, 8'd4, 8'd1}) begin errors++; $display("FAIL dv_cnt got %h exp 030401", err_cnt_o); end
        rep.result_1_i = 32'h0000_0001;
        tick();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dv_sticky got %0d exp 2", state_o); end
        checks++; if (err_cnt_o !== {8'd3, 8'd4, 8'd1}) begin errors++; $display("FAIL dv_nocount got %h exp 030401", err_cnt_o); end
    endtask

    task automatic test_clear();
        nominal();
        rep.result_1_i = 32'h0000_0005;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL cl_state got %0d exp 0", state_o); end
        checks++; if (faulty_mask_o !== 3'b000) begin errors++; $display("FAIL cl_mask got %b exp 000", faulty_mask_o); end
        checks++; if (uncorrectable_o !== 1'b0) begin errors++; $display("FAIL cl_unc got %b exp 0", uncorrectable_o); end
        checks++; if (err_cnt_o !== 24'h0) begin errors++; $display("FAIL cl_cnt got %h exp 000000", err_cnt_o); end
    endtask

    task automatic test_rst_mid();
        nominal();
        rep.result_2_i = 32'h0000_00AA;
        tick();
        checks++; if (err_cnt_o !== {8'd0, 8'd1, 8'd0}) begin errors++; $display("FAIL rm_pre got %h exp 000100", err_cnt_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (err_cnt_o !== 24'h0) begin errors++; $display("FAIL rm_cnt got %h exp 000000", err_cnt_o); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rm_state got %0d exp 0", state_o); end
        checks++; if (faulty_mask_o !== 3'b000) begin errors++; $display("FAIL rm_mask got %b exp 000", faulty_mask_o); end
        tick();
        tick();
        nominal();
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rm_cons got %0d exp 0", state_o); end
        checks++; if (err_cnt_o !== {8'd0, 8'd2, 8'd0}) begin errors++; $display("FAIL rm_cnt2 got %h exp 000200", err_cnt_o); end
    endtask

    task automatic test_gating();
        nominal();
        enable_i = 1'b0;
        rep.result_2_i = 32'h0000_0777;
        #1;
        checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL gt_en_detect got %b exp 0", err_detect_o); end
        checks++; if (result_o !== NOM) begin errors++; $display("FAIL gt_en_result got %h exp %h", result_o, NOM); end
        tick();
        enable_i = 1'b1;
        rep.ready_1_i = 1'b0;
        rep.ready_2_i = 1'b0;
        rep.ready_3_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL gt_ready got %b exp 0", ready_o); end
        checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL gt_rdy_detect got %b exp 0", err_detect_o); end
        tick();
        checks++; if (err_cnt_o !== {8'd0, 8'd2, 8'd0}) begin errors++; $display("FAIL gt_hold got %h exp 000200", err_cnt_o); end
        nominal();
        ex_ready_i = 1'b0;
        rep.result_1_i = 32'h0BAD_0000;
        #1;
        checks++; if (result_o !== NOM) begin errors++; $display("FAIL gt_exr_result got %h exp %h", result_o, NOM); end
        checks++; if (err_detect_o !== 1'b1) begin errors++; $display("FAIL gt_exr_detect got %b exp 1", err_detect_o); end
        tick();
        checks++; if (err_cnt_o !== {8'd0, 8'd2, 8'd1}) begin errors++; $display("FAIL gt_exr_cnt got %h exp 000201", err_cnt_o); end
        nominal();
        tick();
    endtask

    task automatic test_double_thresh();
        for (int i = 0; i < 3; i++) begin
            nominal();
            rep.result_2_i = NOM ^ 32'h1;
            rep.result_3_i = NOM ^ 32'h2;
            #1;
            checks++; if (result_o !== NOM) begin errors++; $display("FAIL dt_result cyc %0d got %h exp %h", i, result_o, NOM); end
            tick();
        end
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dt_state got %0d exp 2", state_o); end
        checks++; if (faulty_mask_o !== 3'b010) begin errors++; $display("FAIL dt_mask got %b exp 010", faulty_mask_o); end
        checks++; if (uncorrectable_o !== 1'b1) begin errors++; $display("FAIL dt_unc got %b exp 1", uncorrectable_o); end
        checks++; if (err_cnt_o !== {8'd3, 8'd5, 8'd1}) begin errors++; $display("FAIL dt_cnt got %h exp 030501", err_cnt_o); end
        nominal();
        rep.result_1_i = 32'h0000_1111;
        rep.result_2_i = 32'h0000_FFFF;
        rep.result_3_i = 32'h0000_1111;
        #1;
        checks++; if (result_o !== 32'h0000_1111) begin errors++; $display("FAIL dt_pair_result got %h exp 00001111", result_o); end
        checks++; if (err_detect_o !== 1'b0) begin errors++; $display("FAIL dt_pair_detect got %b exp 0", err_detect_o); end
        tick();
    endtask

    task automatic test_saturation();
        nominal();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rep.result_1_i = 32'h0000_0100 + 32'(i);
            tick();
            nominal();
            tick();
        end
        checks++; if (s_err_cnt_o !== {2'd0, 2'd0, 2'd3}) begin errors++; $display("FAIL sat_cnt got %h exp 03", s_err_cnt_o); end
        checks++; if (s_state_o !== 2'd0) begin errors++; $display("FAIL sat_state got %0d exp 0", s_state_o); end
        checks++; if (err_cnt_o !== {8'd0, 8'd0, 8'd5}) begin errors++; $display("FAIL sat_wide_cnt got %h exp 000005", err_cnt_o); end
    endtask

    initial begin
        nominal();
        rst = 1'b1;
        test_reset();
        test_fault_free();
        test_transient();
        test_persistent();
        test_divergence();
        test_clear();
        test_rst_mid();
        test_gating();
        test_double_thresh();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
